// File: rtl/sample_gate_pkg.sv
// Shared types and constants for the sample gate filter.
// Gate FSM encoding, clog2 helper and decision latency.
package sample_gate_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HOLD   = 2'd2
  } gate_st_e;

  // Sample-to-decision latency in clocks.
  localparam int DECISION_LAT = 3;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sample_gate_chan.sv
// One channel: L1 magnitude, boxcar average
// and hysteresis/hold gate FSM.
module sample_gate_chan
  import sample_gate_pkg::*;
#(
  parameter int DIN_WIDTH  = 12,
  parameter int AVG_LOG2   = 2,
  parameter int HOLD_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  input  logic [DIN_WIDTH:0]    thr_on_i,
  input  logic [DIN_WIDTH:0]    thr_off_i,
  input  logic [HOLD_WIDTH-1:0] hold_i,
  input  logic                  valid_i,
  input  logic [DIN_WIDTH-1:0]  i_i,
  input  logic [DIN_WIDTH-1:0]  q_i,
  output logic                  open_d_o,
  output logic                  open_o
);

  localparam int MW    = DIN_WIDTH + 1;
  localparam int SW    = MW + AVG_LOG2;
  localparam int DEPTH = 1 << AVG_LOG2;

  // One extra bit keeps |-2^(W-1)| exact.
  function automatic logic [MW-1:0] absx(
    input logic [DIN_WIDTH-1:0] x
  );
    logic [MW-1:0] s;
    s = {x[DIN_WIDTH-1], x};
    return x[DIN_WIDTH-1] ? (~s + MW'(1)) : s;
  endfunction

  logic [MW-1:0]         mag_d;
  logic [MW-1:0]         mag_q;
  logic                  mag_v_q;
  logic [MW-1:0]         hist_q [DEPTH];
  logic [SW-1:0]         sum_q;
  logic                  avg_v_q;
  logic [SW-1:0]         avg;
  logic                  above;
  logic                  below;
  gate_st_e              st_q;
  gate_st_e              st_d;
  logic [HOLD_WIDTH-1:0] cnt_q;
  logic [HOLD_WIDTH-1:0] cnt_d;
  logic                  open_q;

  assign mag_d = absx(i_i) + absx(q_i);
  assign avg   = sum_q >> AVG_LOG2;
  assign above = avg_v_q && (avg > SW'(thr_on_i));
  assign below = avg_v_q && (avg < SW'(thr_off_i));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mag_q   <= '0;
      mag_v_q <= 1'b0;
      avg_v_q <= 1'b0;
      sum_q   <= '0;
      for (int k = 0; k < DEPTH; k++) hist_q[k] <= '0;
    end else begin
      mag_q   <= mag_d;
      mag_v_q <= valid_i;
      avg_v_q <= mag_v_q;
      if (mag_v_q) begin
        hist_q[0] <= mag_q;
        for (int k = 1; k < DEPTH; k++) hist_q[k] <= hist_q[k-1];
        sum_q <= sum_q + SW'(mag_q) - SW'(hist_q[DEPTH-1]);
      end
    end
  end

  // ACTIVE exit is tested before any re-entry.
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    if (!enable_i) begin
      st_d = ST_IDLE;
    end else begin
      unique case (st_q)
        ST_IDLE: begin
          if (above) st_d = ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (below) begin
            if (hold_i == '0) begin
              st_d = ST_IDLE;
            end else begin
              st_d  = ST_HOLD;
              cnt_d = hold_i - HOLD_WIDTH'(1);
            end
          end
        end
        ST_HOLD: begin
          if (above) st_d = ST_ACTIVE;
          else if (cnt_q == '0) st_d = ST_IDLE;
          else cnt_d = cnt_q - HOLD_WIDTH'(1);
        end
        default: st_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      st_q   <= ST_IDLE;
      cnt_q  <= '0;
      open_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      open_q <= (st_d != ST_IDLE);
    end
  end

  assign open_d_o = (st_d != ST_IDLE);
  assign open_o   = open_q;

endmodule

// File: rtl/sample_gate_filter.sv
// N-channel I/Q sample gate: per-channel decision
// plus a shared delay pipe released while open.
module sample_gate_filter
  import sample_gate_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DIN_WIDTH  = 12,
  parameter int AVG_LOG2   = 2,
  parameter int DELAY      = 16,
  parameter int HOLD_WIDTH = 8
) (
  input  logic                          data_clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [DIN_WIDTH:0]            thr_on,
  input  logic [DIN_WIDTH:0]            thr_off,
  input  logic [HOLD_WIDTH-1:0]         hold_cycles,
  input  logic [NUM_CH-1:0]             din_valid,
  input  logic [NUM_CH*DIN_WIDTH-1:0]   din_i,
  input  logic [NUM_CH*DIN_WIDTH-1:0]   din_q,
  output logic [NUM_CH-1:0]             dout_valid,
  output logic [NUM_CH*DIN_WIDTH-1:0]   dout_i,
  output logic [NUM_CH*DIN_WIDTH-1:0]   dout_q,
  output logic [NUM_CH-1:0]             gate_open
);

  localparam int CW = NUM_CH * DIN_WIDTH;
  localparam int NS = DELAY - 1;

  logic [NUM_CH-1:0] open_d;
  logic [NUM_CH-1:0] v_q [NS];
  logic [CW-1:0]     i_q [NS];
  logic [CW-1:0]     q_q [NS];
  logic [NUM_CH-1:0] dv_q;
  logic [CW-1:0]     di_q;
  logic [CW-1:0]     dq_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    sample_gate_chan #(
      .DIN_WIDTH  (DIN_WIDTH),
      .AVG_LOG2   (AVG_LOG2),
      .HOLD_WIDTH (HOLD_WIDTH)
    ) u_chan (
      .clk_i     (data_clk),
      .rst_ni    (rst_n),
      .enable_i  (enable),
      .thr_on_i  (thr_on),
      .thr_off_i (thr_off),
      .hold_i    (hold_cycles),
      .valid_i   (din_valid[c]),
      .i_i       (din_i[c*DIN_WIDTH +: DIN_WIDTH]),
      .q_i       (din_q[c*DIN_WIDTH +: DIN_WIDTH]),
      .open_d_o  (open_d[c]),
      .open_o    (gate_open[c])
    );
  end

  // Final stage pairs the delayed strobe with the gate
  // value that becomes visible in the same cycle.
  always_ff @(posedge data_clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NS; k++) begin
        v_q[k] <= '0;
        i_q[k] <= '0;
        q_q[k] <= '0;
      end
      dv_q <= '0;
      di_q <= '0;
      dq_q <= '0;
    end else begin
      v_q[0] <= din_valid;
      i_q[0] <= din_i;
      q_q[0] <= din_q;
      for (int k = 1; k < NS; k++) begin
        v_q[k] <= v_q[k-1];
        i_q[k] <= i_q[k-1];
        q_q[k] <= q_q[k-1];
      end
      dv_q <= v_q[NS-1] & open_d;
      di_q <= i_q[NS-1];
      dq_q <= q_q[NS-1];
    end
  end

  assign dout_valid = dv_q;
  assign dout_i     = di_q;
  assign dout_q     = dq_q;

endmodule
